// File: rtl/oled_pkg.sv
// Shared definitions for the Pmod OLEDrgb SPI transmit path: FSM states
// and default geometry of the serial link.
package oled_pkg;

   localparam int OLED_CLK_DIV = 16;
   localparam int OLED_WORD_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      HOLD
   } spi_state_t;

endpackage

// File: rtl/spi_half_tick.sv
// Half-SCLK-period timer: counts 0..HALF-1, wraps, and flags the final
// count so the serializer can advance its phase on the following edge.
module spi_half_tick #(
   parameter int HALF = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/oled_spi_serializer.sv
// SPI mode-3 transmit engine for the OLED panel: accepts one word per
// valid/ready handshake and shifts it out MSB-first with CS and D/C.
module oled_spi_serializer
   import oled_pkg::*;
#(
   parameter int CLK_DIV = OLED_CLK_DIV,
   parameter int WORD_W  = OLED_WORD_W
) (
   input  logic              basys_clk,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_dc,
   input  logic              tx_last,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              spi_sclk,
   output logic              spi_mosi,
   output logic              spi_cs_n,
   output logic              spi_dc,
   output logic              busy,
   output logic              word_done
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int BIT_W = $clog2(WORD_W) + 1;
   localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(WORD_W);

   spi_state_t        state, state_nxt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [WORD_W-2:0] shreg;
   logic              last_q;
   logic              tick, tick_clr;
   logic              load, shift, bit_inc;
   logic              sclk_nxt, cs_nxt, mosi_nxt, dc_nxt, done_nxt;

   spi_half_tick #(.HALF(HALF)) u_half_tick (
      .clk   (basys_clk),
      .rst_n (reset_n),
      .clr   (tick_clr),
      .tick  (tick)
   );

   always_comb begin
      state_nxt = state;
      sclk_nxt  = spi_sclk;
      cs_nxt    = spi_cs_n;
      mosi_nxt  = spi_mosi;
      dc_nxt    = spi_dc;
      done_nxt  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      bit_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               state_nxt = SETUP;
               load      = 1'b1;
               cs_nxt    = 1'b0;
               dc_nxt    = tx_dc;
               mosi_nxt  = tx_data[WORD_W-1];
               sclk_nxt  = 1'b1;
            end
         end
         SETUP: begin
            // MSB is already on the line, so this falling edge leaves MOSI alone.
            if (tick) begin
               state_nxt = SHIFT_LO;
               sclk_nxt  = 1'b0;
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               state_nxt = SHIFT_HI;
               sclk_nxt  = 1'b1;
               bit_inc   = 1'b1;
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               if (bit_cnt < BITS_ALL) begin
                  state_nxt = SHIFT_LO;
                  sclk_nxt  = 1'b0;
                  mosi_nxt  = shreg[WORD_W-2];
                  shift     = 1'b1;
               end else if (last_q) begin
                  state_nxt = HOLD;
               end else begin
                  // CS stays asserted so the next word continues the burst.
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_nxt = IDLE;
               cs_nxt    = 1'b1;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      tick_clr = load || (state_nxt != state);
   end

   always_ff @(posedge basys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         spi_sclk  <= 1'b1;
         spi_cs_n  <= 1'b1;
         spi_mosi  <= 1'b0;
         spi_dc    <= 1'b0;
         word_done <= 1'b0;
         busy      <= 1'b0;
         tx_ready  <= 1'b1;
         bit_cnt   <= '0;
         last_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         spi_sclk  <= sclk_nxt;
         spi_cs_n  <= cs_nxt;
         spi_mosi  <= mosi_nxt;
         spi_dc    <= dc_nxt;
         word_done <= done_nxt;
         busy      <= (state_nxt != IDLE);
         tx_ready  <= (state_nxt == IDLE);
         if (load) begin
            bit_cnt <= '0;
            last_q  <= tx_last;
         end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Remaining bits of the word, next one at the top.
   always_ff @(posedge basys_clk) begin
      if (load) begin
         shreg <= tx_data[WORD_W-2:0];
      end else if (shift) begin
         shreg <= {shreg[WORD_W-3:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_oled_spi_serializer.sv
// Directed bench for oled_spi_serializer: a default instance and a
// CLK_DIV=4 instance, observed on the falling system-clock edge.
module tb_oled_spi_serializer;

   logic        basys_clk = 1'b0;
   logic        reset_n   = 1'b0;

   logic [15:0] tx_data_a = '0, tx_data_b = '0;
   logic        tx_dc_a = 0, tx_last_a = 0, tx_valid_a = 0;
   logic        tx_dc_b = 0, tx_last_b = 0, tx_valid_b = 0;
   logic        tx_ready_a, spi_sclk_a, spi_mosi_a, spi_cs_n_a, spi_dc_a, busy_a, word_done_a;
   logic        tx_ready_b, spi_sclk_b, spi_mosi_b, spi_cs_n_b, spi_dc_b, busy_b, word_done_b;

   int n_cmp = 0;
   int n_err = 0;

   // observation state, written only from the stimulus process
   int          rel, o_rises, o_first_rise, o_last_rise, o_done, o_done_at;
   int          o_cs_rises, o_cs_rise_at, o_dc_changes, o_dc_at, o_mosi_bad, idle_bad;
   logic [31:0] o_bits;
   logic        p_sclk, p_mosi, p_cs, p_dc, p_busy;

   always #5 basys_clk = ~basys_clk;

   oled_spi_serializer u_dut_a (
      .basys_clk (basys_clk), .reset_n (reset_n),
      .tx_data   (tx_data_a), .tx_dc (tx_dc_a), .tx_last (tx_last_a),
      .tx_valid  (tx_valid_a), .tx_ready (tx_ready_a),
      .spi_sclk  (spi_sclk_a), .spi_mosi (spi_mosi_a), .spi_cs_n (spi_cs_n_a),
      .spi_dc    (spi_dc_a), .busy (busy_a), .word_done (word_done_a)
   );

   oled_spi_serializer #(.CLK_DIV(4), .WORD_W(16)) u_dut_b (
      .basys_clk (basys_clk), .reset_n (reset_n),
      .tx_data   (tx_data_b), .tx_dc (tx_dc_b), .tx_last (tx_last_b),
      .tx_valid  (tx_valid_b), .tx_ready (tx_ready_b),
      .spi_sclk  (spi_sclk_b), .spi_mosi (spi_mosi_b), .spi_cs_n (spi_cs_n_b),
      .spi_dc    (spi_dc_b), .busy (busy_b), .word_done (word_done_b)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic obs_start(input bit use_b);
      rel = 0; o_rises = 0; o_first_rise = -1; o_last_rise = -1; o_done = 0; o_done_at = -1;
      o_cs_rises = 0; o_cs_rise_at = -1; o_dc_changes = 0; o_dc_at = -1; o_mosi_bad = 0;
      o_bits = '0;
      p_sclk = use_b ? spi_sclk_b : spi_sclk_a;
      p_mosi = use_b ? spi_mosi_b : spi_mosi_a;
      p_cs   = use_b ? spi_cs_n_b : spi_cs_n_a;
      p_dc   = use_b ? spi_dc_b   : spi_dc_a;
      p_busy = use_b ? busy_b     : busy_a;
   endtask

   task automatic step_obs(input bit use_b);
      logic s, m, c, d, b, w;
      @(negedge basys_clk);
      rel++;
      s = use_b ? spi_sclk_b  : spi_sclk_a;
      m = use_b ? spi_mosi_b  : spi_mosi_a;
      c = use_b ? spi_cs_n_b  : spi_cs_n_a;
      d = use_b ? spi_dc_b    : spi_dc_a;
      b = use_b ? busy_b      : busy_a;
      w = use_b ? word_done_b : word_done_a;
      if (s && !p_sclk) begin
         o_rises++;
         o_bits = {o_bits[30:0], m};
         if (o_first_rise < 0) o_first_rise = rel;
         o_last_rise = rel;
      end
      if ((m !== p_mosi) && !((p_sclk && !s) || (!p_busy && b))) o_mosi_bad++;
      if (c && !p_cs) begin o_cs_rises++; o_cs_rise_at = rel; end
      if (d !== p_dc) begin o_dc_changes++; o_dc_at = rel; end
      if (w) begin o_done++; o_done_at = rel; end
      p_sclk = s; p_mosi = m; p_cs = c; p_dc = d; p_busy = b;
   endtask

   initial begin
      // reset state: {ready, sclk, cs_n, mosi, dc, done, busy}
      repeat (3) @(negedge basys_clk);
      check("rst_a", {tx_ready_a, spi_sclk_a, spi_cs_n_a, spi_mosi_a, spi_dc_a, word_done_a, busy_a}, 7'b1110000);
      check("rst_b", {tx_ready_b, spi_sclk_b, spi_cs_n_b, spi_mosi_b, spi_dc_b, word_done_b, busy_b}, 7'b1110000);
      reset_n = 1'b1;
      repeat (2) @(negedge basys_clk);

      // single last word 0xA5C3, data
      obs_start(0);
      tx_data_a = 16'hA5C3; tx_dc_a = 1; tx_last_a = 1; tx_valid_a = 1;
      step_obs(0);
      tx_valid_a = 0;
      check("t1_accept", {tx_ready_a, spi_cs_n_a, spi_mosi_a, spi_sclk_a, spi_dc_a, busy_a}, 6'b001111);
      while (rel < 280) step_obs(0);
      check("t1_bits",       o_bits[15:0], 16'hA5C3);
      check("t1_rises",      o_rises, 16);
      check("t1_first_rise", o_first_rise, 17);
      check("t1_last_rise",  o_last_rise, 257);
      check("t1_done_cnt",   o_done, 1);
      check("t1_done_at",    o_done_at, 273);
      check("t1_cs_rise_at", o_cs_rise_at, 273);
      check("t1_dc_at",      o_dc_at, 1);
      check("t1_mosi_edges", o_mosi_bad, 0);
      check("t1_idle_after", {tx_ready_a, busy_a, spi_cs_n_a, spi_dc_a}, 4'b1011);

      // back-to-back 0x00FF (cmd, not last) then 0x8001 (data, last)
      repeat (3) @(negedge basys_clk);
      obs_start(0);
      tx_data_a = 16'h00FF; tx_dc_a = 0; tx_last_a = 0; tx_valid_a = 1;
      step_obs(0);
      tx_data_a = 16'h8001; tx_dc_a = 1; tx_last_a = 1;
      while (rel < 545) begin
         step_obs(0);
         if (rel == 266) tx_valid_a = 0;
      end
      check("t2_bits",       o_bits, 32'h00FF8001);
      check("t2_rises",      o_rises, 32);
      check("t2_done_cnt",   o_done, 2);
      check("t2_cs_rises",   o_cs_rises, 1);
      check("t2_cs_rise_at", o_cs_rise_at, 538);
      check("t2_dc_changes", o_dc_changes, 2);
      check("t2_dc_at",      o_dc_at, 266);
      check("t2_mosi_edges", o_mosi_bad, 0);

      // 0xFFFF offered mid-shift of 0x1234 must be ignored
      repeat (3) @(negedge basys_clk);
      obs_start(0);
      tx_data_a = 16'h1234; tx_dc_a = 0; tx_last_a = 1; tx_valid_a = 1;
      step_obs(0);
      tx_valid_a = 0;
      while (rel < 285) begin
         step_obs(0);
         if (rel == 100) begin
            check("t3_ready_busy", tx_ready_a, 1'b0);
            tx_data_a = 16'hFFFF; tx_dc_a = 1; tx_valid_a = 1;
         end
         if (rel == 101) tx_valid_a = 0;
      end
      check("t3_bits",       o_bits[15:0], 16'h1234);
      check("t3_rises",      o_rises, 16);
      check("t3_done_cnt",   o_done, 1);
      check("t3_cs_rise_at", o_cs_rise_at, 273);
      check("t3_dc_changes", o_dc_changes, 1);

      // asynchronous reset mid-word, then a fresh word
      repeat (3) @(negedge basys_clk);
      obs_start(0);
      tx_data_a = 16'hABCD; tx_dc_a = 1; tx_last_a = 1; tx_valid_a = 1;
      step_obs(0);
      tx_valid_a = 0;
      while (rel < 100) step_obs(0);
      check("t4_pre_busy", busy_a, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      // {cs_n, sclk, mosi, busy, done, ready, dc}
      check("t4_async_rst", {spi_cs_n_a, spi_sclk_a, spi_mosi_a, busy_a, word_done_a, tx_ready_a, spi_dc_a}, 7'b1100010);
      repeat (3) @(negedge basys_clk);
      reset_n = 1'b1;
      obs_start(0);
      while (rel < 3) step_obs(0);
      check("t4_no_done_after_rst", o_done, 0);
      obs_start(0);
      tx_data_a = 16'h5A96; tx_dc_a = 0; tx_last_a = 1; tx_valid_a = 1;
      step_obs(0);
      tx_valid_a = 0;
      while (rel < 280) step_obs(0);
      check("t4_bits",       o_bits[15:0], 16'h5A96);
      check("t4_rises",      o_rises, 16);
      check("t4_first_rise", o_first_rise, 17);
      check("t4_done_at",    o_done_at, 273);
      check("t4_cs_rise_at", o_cs_rise_at, 273);

      // CLK_DIV = 4 instance, word 0x0001
      repeat (2) @(negedge basys_clk);
      obs_start(1);
      tx_data_b = 16'h0001; tx_dc_b = 1; tx_last_b = 1; tx_valid_b = 1;
      step_obs(1);
      tx_valid_b = 0;
      while (rel < 80) step_obs(1);
      check("t5_bits",       o_bits[15:0], 16'h0001);
      check("t5_rises",      o_rises, 16);
      check("t5_first_rise", o_first_rise, 5);
      check("t5_last_rise",  o_last_rise, 65);
      check("t5_done_cnt",   o_done, 1);
      check("t5_done_at",    o_done_at, 69);
      check("t5_cs_rise_at", o_cs_rise_at, 69);
      check("t5_mosi_edges", o_mosi_bad, 0);

      // idle for 1000 cycles
      idle_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge basys_clk);
         if (!(spi_sclk_a === 1'b1 && spi_cs_n_a === 1'b1 && tx_ready_a === 1'b1 && word_done_a === 1'b0))
            idle_bad++;
      end
      check("t6_idle", idle_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
